// File: rtl/buf_pkg.sv
// Shared constants for the flag FIFO buffer: default sizing and full-handling modes.
package buf_pkg;
  localparam int W_DEF      = 8;
  localparam int ADDR_W_DEF = 2;
  localparam int OVR_DROP   = 0;
  localparam int OVR_OLDEST = 1;
endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, count and overrun bookkeeping for the flag FIFO, plus status decode.
module fifo_ptr_ctrl
  import buf_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AF_LEVEL  = 3,
  parameter int OVERWRITE = OVR_DROP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_flag,
  input  logic              clr_flag,
  input  logic              clr_ovr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              overrun
);
  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(1 << ADDR_W);
  localparam logic [ADDR_W:0] C_AF    = (ADDR_W+1)'(AF_LEVEL);
  localparam bit C_OLDEST = (OVERWRITE == OVR_OLDEST);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overrun;

  logic w_empty, w_full, w_pop, w_wr, w_ovr_evt, w_rd_adv;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == C_DEPTH);
  assign w_pop     = clr_flag && !w_empty;
  // A pop in the same cycle frees the slot, so a full buffer then accepts the write cleanly.
  assign w_ovr_evt = set_flag && w_full && !w_pop;
  assign w_wr      = set_flag && (!w_ovr_evt || C_OLDEST);
  assign w_rd_adv  = w_pop || (w_ovr_evt && C_OLDEST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_adv)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr && !w_rd_adv)
        r_count <= r_count + 1'b1;
      else if (w_rd_adv && !w_wr)
        r_count <= r_count - 1'b1;
      if (w_ovr_evt)
        r_overrun <= 1'b1;
      else if (clr_ovr)
        r_overrun <= 1'b0;
    end
  end

  assign wr_en       = w_wr;
  assign wr_ptr      = r_wr_ptr;
  assign rd_ptr      = r_rd_ptr;
  assign count       = r_count;
  assign empty       = w_empty;
  assign full        = w_full;
  assign almost_full = (r_count >= C_AF);
  assign overrun     = r_overrun;
endmodule

// File: rtl/flag_fifo_buf.sv
// Multi-entry flag buffer between a byte producer and a consumer; show-ahead head on dout.
module flag_fifo_buf
  import buf_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AF_LEVEL  = 3,
  parameter int OVERWRITE = OVR_DROP
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_flag,
  input  logic [W-1:0]  din,
  input  logic          clr_flag,
  input  logic          clr_ovr,
  output logic [W-1:0]  dout,
  output logic          flag,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic [ADDR_W:0] count,
  output logic          overrun
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [W-1:0]      r_mem [DEPTH];
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_ptr;
  logic [ADDR_W-1:0] w_rd_ptr;
  logic              w_empty;

  fifo_ptr_ctrl #(
    .ADDR_W    (ADDR_W),
    .AF_LEVEL  (AF_LEVEL),
    .OVERWRITE (OVERWRITE)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .set_flag    (set_flag),
    .clr_flag    (clr_flag),
    .clr_ovr     (clr_ovr),
    .wr_en       (w_wr_en),
    .wr_ptr      (w_wr_ptr),
    .rd_ptr      (w_rd_ptr),
    .count       (count),
    .empty       (w_empty),
    .full        (full),
    .almost_full (almost_full),
    .overrun     (overrun)
  );

  // Storage is deliberately left out of reset; dout is masked while empty instead.
  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_mem[w_wr_ptr] <= din;
  end

  assign dout  = w_empty ? '0 : r_mem[w_rd_ptr];
  assign empty = w_empty;
  assign flag  = !w_empty;
endmodule

// File: tb/tb_flag_fifo_buf.sv
// Bench for flag_fifo_buf: drop-newest and overwrite-oldest instances against an ordered-list model.
module tb_flag_fifo_buf;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       set_flag = 1'b0;
  logic [7:0] din = 8'h00;
  logic       clr_flag = 1'b0;
  logic       clr_ovr = 1'b0;

  logic [7:0] dout0, dout1;
  logic       flag0, flag1, empty0, empty1, full0, full1, af0, af1, ovr0, ovr1;
  logic [2:0] count0, count1;

  int total = 0;
  int bad = 0;

  // model: per mode an ordered list, head at index 0
  logic [7:0] mdat [2][4];
  int         msize [2];
  bit         movr [2];

  always #5 clk = ~clk;

  flag_fifo_buf #(.W(8), .ADDR_W(2), .AF_LEVEL(3), .OVERWRITE(0)) u_drop (
    .clk(clk), .reset(reset), .set_flag(set_flag), .din(din), .clr_flag(clr_flag),
    .clr_ovr(clr_ovr), .dout(dout0), .flag(flag0), .empty(empty0), .full(full0),
    .almost_full(af0), .count(count0), .overrun(ovr0));

  flag_fifo_buf #(.W(8), .ADDR_W(2), .AF_LEVEL(3), .OVERWRITE(1)) u_old (
    .clk(clk), .reset(reset), .set_flag(set_flag), .din(din), .clr_flag(clr_flag),
    .clr_ovr(clr_ovr), .dout(dout1), .flag(flag1), .empty(empty1), .full(full1),
    .almost_full(af1), .count(count1), .overrun(ovr1));

  logic [14:0] obs0, obs1;
  assign obs0 = {dout0, flag0, empty0, full0, af0, count0, ovr0};
  assign obs1 = {dout1, flag1, empty1, full1, af1, count1, ovr1};

  function automatic logic [14:0] exp_vec(input int m);
    logic [7:0] d;
    d = (msize[m] > 0) ? mdat[m][0] : 8'h00;
    return {d, msize[m] > 0, msize[m] == 0, msize[m] == 4, msize[m] >= 3,
            3'(msize[m]), movr[m]};
  endfunction

  function automatic void model_clear();
    for (int m = 0; m < 2; m++) begin
      msize[m] = 0;
      movr[m] = 1'b0;
    end
  endfunction

  function automatic void model_pop(input int m);
    for (int i = 0; i < 3; i++) mdat[m][i] = mdat[m][i+1];
    msize[m] = msize[m] - 1;
  endfunction

  function automatic void model_push(input int m, input logic [7:0] d);
    mdat[m][msize[m]] = d;
    msize[m] = msize[m] + 1;
  endfunction

  function automatic void model_update(input int m, input bit s, input logic [7:0] d,
                                       input bit p, input bit c);
    bit ovr_evt;
    ovr_evt = 1'b0;
    if (msize[m] == 4 && s) begin
      if (p) begin
        model_pop(m);
        model_push(m, d);
      end else begin
        ovr_evt = 1'b1;
        if (m == 1) begin
          model_pop(m);
          model_push(m, d);
        end
      end
    end else begin
      if (p && msize[m] > 0) model_pop(m);
      if (s) model_push(m, d);
    end
    if (ovr_evt) movr[m] = 1'b1;
    else if (c) movr[m] = 1'b0;
  endfunction

  task automatic step(input bit s, input logic [7:0] d, input bit p, input bit c);
    set_flag = s; din = d; clr_flag = p; clr_ovr = c;
    @(posedge clk);
    for (int m = 0; m < 2; m++) model_update(m, s, d, p, c);
    @(negedge clk);
    set_flag = 1'b0; clr_flag = 1'b0; clr_ovr = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (obs0 !== exp_vec(0)) begin bad++; $display("FAIL reset_drop got=%h exp=%h", obs0, exp_vec(0)); end
    total++; if (obs1 !== exp_vec(1)) begin bad++; $display("FAIL reset_old got=%h exp=%h", obs1, exp_vec(1)); end
    total++; if ({empty0, flag0, count0, dout0} !== {1'b1, 1'b0, 3'd0, 8'h00}) begin
      bad++; $display("FAIL reset_const got=%b/%b/%0d/%h exp=1/0/0/00", empty0, flag0, count0, dout0);
    end
    step(0, 8'h00, 1, 0);
    total++; if (obs0 !== exp_vec(0)) begin bad++; $display("FAIL pop_empty_drop got=%h exp=%h", obs0, exp_vec(0)); end
    total++; if (obs1 !== exp_vec(1)) begin bad++; $display("FAIL pop_empty_old got=%h exp=%h", obs1, exp_vec(1)); end
  endtask

  task automatic test_basic();
    logic [7:0] vals [3];
    vals[0] = 8'hA1; vals[1] = 8'hB2; vals[2] = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      step(1, vals[i], 0, 0);
      total++; if (obs0 !== exp_vec(0)) begin bad++; $display("FAIL basic_wr%0d got=%h exp=%h", i, obs0, exp_vec(0)); end
    end
    total++; if ({dout0, af0, count0} !== {8'hA1, 1'b1, 3'd3}) begin
      bad++; $display("FAIL basic_head got=%h/%b/%0d exp=a1/1/3", dout0, af0, count0);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00, 1, 0);
      total++; if (obs0 !== exp_vec(0)) begin bad++; $display("FAIL basic_pop%0d got=%h exp=%h", i, obs0, exp_vec(0)); end
      total++; if (obs1 !== exp_vec(1)) begin bad++; $display("FAIL basic_pop_old%0d got=%h exp=%h", i, obs1, exp_vec(1)); end
    end
  endtask

  task automatic test_full_modes();
    for (int i = 0; i < 5; i++) step(1, 8'(8'h10 + i), 0, 0);
    total++; if (obs0 !== exp_vec(0)) begin bad++; $display("FAIL full_drop got=%h exp=%h", obs0, exp_vec(0)); end
    total++; if (obs1 !== exp_vec(1)) begin bad++; $display("FAIL full_old got=%h exp=%h", obs1, exp_vec(1)); end
    total++; if ({full0, ovr0, dout0, ovr1, dout1} !== {1'b1, 1'b1, 8'h10, 1'b1, 8'h11}) begin
      bad++; $display("FAIL full_heads got=%b/%b/%h/%b/%h exp=1/1/10/1/11", full0, ovr0, dout0, ovr1, dout1);
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (dout0 !== 8'(8'h10 + i) || dout1 !== 8'(8'h11 + i)) begin
        bad++; $display("FAIL full_order%0d got=%h/%h exp=%h/%h", i, dout0, dout1, 8'(8'h10 + i), 8'(8'h11 + i));
      end
      step(0, 8'h00, 1, 0);
    end
    step(0, 8'h00, 0, 1);
    total++; if (obs0 !== exp_vec(0)) begin bad++; $display("FAIL clr_ovr_drop got=%h exp=%h", obs0, exp_vec(0)); end
    total++; if (obs1 !== exp_vec(1)) begin bad++; $display("FAIL clr_ovr_old got=%h exp=%h", obs1, exp_vec(1)); end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 4; i++) step(1, 8'($urandom_range(0, 255)), 0, 0);
    step(1, 8'h55, 1, 0);
    total++; if (obs0 !== exp_vec(0)) begin bad++; $display("FAIL fsim_drop got=%h exp=%h", obs0, exp_vec(0)); end
    total++; if (obs1 !== exp_vec(1)) begin bad++; $display("FAIL fsim_old got=%h exp=%h", obs1, exp_vec(1)); end
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        total++; if (dout0 !== 8'h55 || dout1 !== 8'h55) begin
          bad++; $display("FAIL fsim_last got=%h/%h exp=55/55", dout0, dout1);
        end
      end
      step(0, 8'h00, 1, 0);
      total++; if (obs0 !== exp_vec(0)) begin bad++; $display("FAIL fsim_pop%0d got=%h exp=%h", i, obs0, exp_vec(0)); end
    end
  endtask

  task automatic test_empty_simul();
    step(1, 8'h7E, 1, 0);
    total++; if (obs0 !== exp_vec(0)) begin bad++; $display("FAIL esim_drop got=%h exp=%h", obs0, exp_vec(0)); end
    total++; if (obs1 !== exp_vec(1)) begin bad++; $display("FAIL esim_old got=%h exp=%h", obs1, exp_vec(1)); end
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 0, 0);
    set_flag = 1'b1; din = 8'h99; clr_flag = 1'b1;
    #3 reset = 1'b1;
    #1;
    model_clear();
    total++; if ({count0, empty0, count1, empty1} !== {3'd0, 1'b1, 3'd0, 1'b1}) begin
      bad++; $display("FAIL async_reset got=%0d/%b/%0d/%b exp=0/1/0/1", count0, empty0, count1, empty1);
    end
    set_flag = 1'b0; clr_flag = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    total++; if (obs1 !== exp_vec(1)) begin bad++; $display("FAIL reset_hold got=%h exp=%h", obs1, exp_vec(1)); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      step(1, 8'(8'h20 + i), 0, 0);
      total++; if (dout0 !== 8'(8'h20 + i) || count0 !== 3'd1 || obs1 !== exp_vec(1)) begin
        bad++; $display("FAIL wrap_wr%0d got=%h/%0d exp=%h/1", i, dout0, count0, 8'(8'h20 + i));
      end
      step(0, 8'h00, 1, 0);
      total++; if (count0 !== 3'd0 || ovr0 !== 1'b0 || ovr1 !== 1'b0) begin
        bad++; $display("FAIL wrap_pop%0d got=%0d/%b/%b exp=0/0/0", i, count0, ovr0, ovr1);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(($urandom % 100) < 55, 8'($urandom), ($urandom % 100) < 40, ($urandom % 100) < 10);
      total++; if (obs0 !== exp_vec(0)) begin bad++; $display("FAIL rand_drop%0d got=%h exp=%h", i, obs0, exp_vec(0)); end
      total++; if (obs1 !== exp_vec(1)) begin bad++; $display("FAIL rand_old%0d got=%h exp=%h", i, obs1, exp_vec(1)); end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_full_modes();
    test_full_simul();
    test_empty_simul();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
